// File: rtl/step_ramp_ctrl_if.sv
// Bus between the step-rate controller and its host/divider side.
// The host drives the move command and the divider step output; the controller drives the divider.
interface step_ramp_ctrl_if;
    logic        start;
    logic        abort;
    logic        dir;
    logic [31:0] steps;
    logic [31:0] div_start;
    logic [31:0] div_min;
    logic [31:0] div_dec;
    logic        step_in;
    logic [31:0] div_cnt;
    logic        div_xres;
    logic        motor_dir;
    logic        busy;
    logic        done;
    logic [31:0] step_cnt;

    modport master (
        output start, abort, dir, steps, div_start, div_min, div_dec, step_in,
        input  div_cnt, div_xres, motor_dir, busy, done, step_cnt
    );

    modport slave (
        input  start, abort, dir, steps, div_start, div_min, div_dec, step_in,
        output div_cnt, div_xres, motor_dir, busy, done, step_cnt
    );
endinterface

// File: rtl/step_ramp_ctrl.sv
// Trapezoidal step-rate controller: ramps the divider count from div_start down to div_min,
// cruises, then ramps back up so the move lands on the commanded step count; supports abort.
module step_ramp_ctrl (
    input  logic             clk,
    input  logic             xres,
    step_ramp_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_CRUISE,
        S_DECEL,
        S_DONE
    } state_e;

    state_e      state_q,     state_d;
    logic [31:0] div_cnt_q,   div_cnt_d;
    logic        div_xres_q,  div_xres_d;
    logic        motor_dir_q, motor_dir_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic [31:0] step_cnt_q,  step_cnt_d;
    logic [31:0] ramp_q,      ramp_d;
    logic        abort_q,     abort_d;
    logic        step_dly_q,  step_dly_d;
    logic [31:0] steps_q,     steps_d;
    logic [31:0] div_start_q, div_start_d;
    logic [31:0] div_min_q,   div_min_d;
    logic [31:0] div_dec_q,   div_dec_d;

    logic        step_ev;
    logic [31:0] cnt_inc;
    logic [31:0] rem;
    logic [32:0] sum_up;
    logic [31:0] up_val;
    logic [32:0] accel_floor;
    logic        abort_eff;
    logic        decel_evt;

    assign step_ev = bus.step_in && !step_dly_q;

    always_comb begin
        // NOTE: every _d and temporary gets a value first so no path through the case infers a latch.
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        motor_dir_d = motor_dir_q;
        step_cnt_d  = step_cnt_q;
        ramp_d      = ramp_q;
        abort_d     = abort_q;
        step_dly_d  = 1'b0;
        steps_d     = steps_q;
        div_start_d = div_start_q;
        div_min_d   = div_min_q;
        div_dec_d   = div_dec_q;

        cnt_inc     = step_cnt_q + 32'd1;
        rem         = steps_q - cnt_inc;
        sum_up      = {1'b0, div_cnt_q} + {1'b0, div_dec_q};
        up_val      = (sum_up >= {1'b0, div_start_q}) ? div_start_q : sum_up[31:0];
        accel_floor = {1'b0, div_min_q} + {1'b0, div_dec_q};
        abort_eff   = abort_q;
        decel_evt   = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_cnt_d = bus.div_start;
                if (bus.start) begin
                    steps_d     = bus.steps;
                    div_start_d = bus.div_start;
                    div_min_d   = bus.div_min;
                    div_dec_d   = bus.div_dec;
                    motor_dir_d = bus.dir;
                    step_cnt_d  = 32'd0;
                    ramp_d      = 32'd0;
                    state_d     = (bus.steps != 32'd0) ? S_ACCEL : S_DONE;
                end
            end

            S_ACCEL, S_CRUISE: begin
                step_dly_d = bus.step_in;
                if (bus.abort) begin
                    abort_d   = 1'b1;
                    abort_eff = 1'b1;
                    state_d   = S_DECEL;
                    decel_evt = step_ev;
                end else if (step_ev) begin
                    step_cnt_d = cnt_inc;
                    if (rem == 32'd0) begin
                        state_d = S_DONE;
                    end else if (rem <= ramp_q) begin
                        state_d   = S_DECEL;
                        div_cnt_d = up_val;
                    end else if (state_q == S_ACCEL) begin
                        ramp_d = ramp_q + 32'd1;
                        // Clamp at div_min instead of subtracting past it (33-bit so no wrap).
                        if ({1'b0, div_cnt_q} < accel_floor) begin
                            div_cnt_d = div_min_q;
                            state_d   = S_CRUISE;
                        end else begin
                            div_cnt_d = div_cnt_q - div_dec_q;
                        end
                    end
                end
            end

            S_DECEL: begin
                step_dly_d = bus.step_in;
                if (bus.abort) begin
                    abort_d   = 1'b1;
                    abort_eff = 1'b1;
                end
                decel_evt = step_ev;
            end

            S_DONE: begin
                state_d = S_IDLE;
                abort_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared deceleration rules, also used by an abort that coincides with a step.
        if (decel_evt) begin
            step_cnt_d = cnt_inc;
            if (rem == 32'd0 || (abort_eff && div_cnt_q == div_start_q)) begin
                state_d = S_DONE;
            end else begin
                div_cnt_d = up_val;
            end
        end

        div_xres_d = (state_d == S_ACCEL) || (state_d == S_CRUISE) || (state_d == S_DECEL);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // NOTE: non-blocking only here; a blocking write would let flops later in the block see this edge's value.
    always_ff @(posedge clk or negedge xres) begin
        if (!xres) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= 32'd0;
            div_xres_q  <= 1'b0;
            motor_dir_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_cnt_q  <= 32'd0;
            ramp_q      <= 32'd0;
            abort_q     <= 1'b0;
            step_dly_q  <= 1'b0;
            steps_q     <= 32'd0;
            div_start_q <= 32'd0;
            div_min_q   <= 32'd0;
            div_dec_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            div_xres_q  <= div_xres_d;
            motor_dir_q <= motor_dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            step_cnt_q  <= step_cnt_d;
            ramp_q      <= ramp_d;
            abort_q     <= abort_d;
            step_dly_q  <= step_dly_d;
            steps_q     <= steps_d;
            div_start_q <= div_start_d;
            div_min_q   <= div_min_d;
            div_dec_q   <= div_dec_d;
        end
    end

    assign bus.div_cnt   = div_cnt_q;
    assign bus.div_xres  = div_xres_q;
    assign bus.motor_dir = motor_dir_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.step_cnt  = step_cnt_q;

endmodule
